// File: rtl/result_dump_tx.sv
// Snapshots WORDS 12-bit result words and streams them as UART 8N1 bytes, high byte first.
// Optional macro DUMP_CHECKSUM_EN appends a modulo-256 sum frame. All outputs registered.
module result_dump_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int WORDS        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [12*WORDS-1:0]   res_flat,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(2*WORDS+1);
  localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT-1);
`ifdef DUMP_CHECKSUM_EN
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(2*WORDS);
`else
  localparam logic [BIW-1:0] LAST_BYTE = BIW'(2*WORDS-1);
`endif

  state_t              state, state_nxt;
  logic [BW-1:0]       baud_cnt, baud_nxt;
  logic [2:0]          bit_cnt, bit_nxt;
  logic [BIW-1:0]      byte_idx, byte_nxt;
  logic [12*WORDS-1:0] snap;
  logic                load;
  logic                bit_end;
  logic                tx_nxt, done_nxt;
  logic [WIW-1:0]      word_idx;
  logic [11:0]         word;
  logic [7:0]          data_byte, cur_byte;

  assign word_idx  = WIW'(byte_idx >> 1);
  assign word      = snap[12*word_idx +: 12];
  assign data_byte = byte_idx[0] ? word[7:0] : {4'b0000, word[11:8]};
  assign bit_end   = (baud_cnt == BAUD_MAX);

`ifdef DUMP_CHECKSUM_EN
  logic [7:0] csum;

  assign cur_byte = (byte_idx == LAST_BYTE) ? csum : data_byte;

  // Each data byte is folded in as its stop bit ends, so the sum is complete before the checksum frame's data bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      csum <= 8'h00;
    else if (load)
      csum <= 8'h00;
    else if (state == STOP_BIT && bit_end && byte_idx != LAST_BYTE)
      csum <= csum + data_byte;
  end
`else
  assign cur_byte = data_byte;
`endif

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_idx;
    load      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          byte_nxt  = '0;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA_BITS;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          baud_nxt = '0;
          bit_nxt  = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7)
            state_nxt = STOP_BIT;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (byte_idx == LAST_BYTE) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            byte_nxt  = byte_idx + 1'b1;
            state_nxt = START_BIT;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is decided from the next state so tx is a plain register with no start-to-pin path.
    case (state_nxt)
      START_BIT: tx_nxt = 1'b0;
      DATA_BITS: tx_nxt = cur_byte[bit_nxt];
      default:   tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      snap     <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      byte_idx <= byte_nxt;
      if (load)
        snap <= res_flat;
      tx       <= tx_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
    end
  end

endmodule
